ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- It is the transmit side of the PS/2 link whose receive side decodes scan codes (make codes, 0xF0 break prefix) into key events.
- It drives the open-collector PS/2 clock and data lines through output-enable pins.
- It reports completion and device acknowledge to the controlling logic.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmit path and the scan-code receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    RELEASE,
    DONE
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_CMD_LED   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_ACK       = 8'hFA;

  // PS/2 frames use odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status and open-collector pad signals of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, nack
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, nack
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: multi-stage synchronizer for the PS/2 clock and data pads plus clock falling-edge detect.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);
  logic [SYNC_STAGES-1:0] clk_pipe_reg;
  logic [SYNC_STAGES-1:0] data_pipe_reg;
  logic                   clk_prev_reg;

  // Pipes reset to the idle (released, high) line level so no fall is seen out of reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_pipe_reg  <= '1;
      data_pipe_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_pipe_reg  <= {clk_pipe_reg[SYNC_STAGES-2:0], ps2_clk_in};
      data_pipe_reg <= {data_pipe_reg[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev_reg  <= clk_pipe_reg[SYNC_STAGES-1];
    end
  end

  assign clk_sync  = clk_pipe_reg[SYNC_STAGES-1];
  assign data_sync = data_pipe_reg[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_reg & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving the open-collector lines via oe pins.
// Build option PS2_HOST_TX_RETRY_EN: resend the latched byte once after a nack or timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 3
) (
  input logic          clk,
  input logic          clr,
  ps2_host_tx_if.slave bus
);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [9:0]    frame_reg, frame_next;
  logic          data_oe_reg, data_oe_next;
  logic          nack_reg, nack_next;
  logic          clk_sync, data_sync, clk_fall;
  logic          timed, timeout, give_up;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk_in (bus.ps2_clk_in),
    .ps2_data_in(bus.ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

`ifdef PS2_HOST_TX_RETRY_EN
  // Set once the first attempt has failed; the second attempt's result is final.
  logic retried_reg;
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                            retried_reg <= 1'b0;
    else if (state_reg == IDLE)                         retried_reg <= 1'b0;
    else if (state_next == INHIBIT && state_reg != INHIBIT) retried_reg <= 1'b1;
  end
  assign give_up = retried_reg;
`else
  assign give_up = 1'b1;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      frame_reg   <= '0;
      data_oe_reg <= 1'b0;
      nack_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      frame_reg   <= frame_next;
      data_oe_reg <= data_oe_next;
      nack_reg    <= nack_next;
    end
  end

  assign timed   = (state_reg == REQ) || (state_reg == BITS) ||
                   (state_reg == ACK) || (state_reg == RELEASE);
  assign timeout = timed && (cnt_reg == TIMEOUT_LAST);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    frame_next   = frame_reg;
    data_oe_next = data_oe_reg;
    nack_next    = nack_reg;
    if (timed) cnt_next = cnt_reg + 1'b1;

    // Timeout takes priority over any clock fall seen in the same cycle.
    if (timeout) begin
      data_oe_next = 1'b0;
      nack_next    = 1'b1;
      cnt_next     = '0;
      state_next   = give_up ? DONE : INHIBIT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.tx_valid) begin
            frame_next   = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
            nack_next    = 1'b0;
            cnt_next     = '0;
            data_oe_next = 1'b0;
            state_next   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_reg == INHIBIT_LAST) begin
            cnt_next     = '0;
            data_oe_next = 1'b1;
            state_next   = REQ;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        REQ: begin
          idx_next   = '0;
          cnt_next   = '0;
          state_next = BITS;
        end
        BITS: begin
          if (clk_fall) begin
            data_oe_next = ~frame_reg[idx_reg];
            if (idx_reg == 4'd9) state_next = ACK;
            else                 idx_next   = idx_reg + 4'd1;
          end
        end
        ACK: begin
          if (clk_fall) begin
            nack_next  = data_sync;
            state_next = RELEASE;
          end
        end
        RELEASE: begin
          if (clk_sync && data_sync) begin
            cnt_next   = '0;
            state_next = (nack_reg && !give_up) ? INHIBIT : DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.ps2_clk_oe  = (state_reg == INHIBIT);
  assign bus.ps2_data_oe = data_oe_reg;
  assign bus.tx_ready    = (state_reg == IDLE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = (state_reg == DONE);
  assign bus.nack        = nack_reg;

endmodule
